// File: rtl/pe_mac_pipe.sv
// Two-stage pipelined signed MAC processing element with stationary weight, chain/local modes.
// Optional macro PE_SAT_EN: clamp out-of-range results and report them on oSAT.
module pe_mac_pipe #(
    parameter int XW  = 16,
    parameter int WW  = 16,
    parameter int PSW = 34,
    parameter int OW  = 35
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    input  logic                  iVALID,
    input  logic signed [XW-1:0]  iX,
    input  logic                  iWLOAD,
    input  logic signed [WW-1:0]  iW,
    input  logic                  iMODE,
    input  logic                  iCLR,
    input  logic signed [PSW-1:0] iPsum,
    output logic signed [XW-1:0]  oX,
    output logic                  oXVALID,
    output logic signed [OW-1:0]  oPsum,
    output logic                  oVALID,
    output logic                  oSAT
);

    localparam int PW = XW + WW;
`ifdef PE_SAT_EN
    localparam int SW = OW + 1;
`else
    localparam int SW = OW;
`endif

    logic signed [WW-1:0]  wreg_q;
    logic signed [XW-1:0]  x_q;
    logic                  xvalid_q;
    logic signed [PW-1:0]  prod_q, prod_d;
    logic signed [PSW-1:0] psum_q;
    logic                  mode_q, clr_q, v1_q;
    logic signed [OW-1:0]  acc_q, opsum_q, opsum_d;
    logic                  ovalid_q;
    logic signed [PW-1:0]  x_ext, w_ext;
    logic signed [SW-1:0]  prod_ext, psum_ext, acc_ext, sum;
`ifdef PE_SAT_EN
    logic                  osat_q, ovf;
`endif

    always_comb begin
        x_ext  = PW'(iX);
        w_ext  = PW'(wreg_q);
        prod_d = x_ext * w_ext;

        prod_ext = SW'(prod_q);
        psum_ext = SW'(psum_q);
        acc_ext  = clr_q ? '0 : SW'(acc_q);
        sum      = mode_q ? (acc_ext + prod_ext) : (psum_ext + prod_ext);
`ifdef PE_SAT_EN
        // Sign bit disagreeing with the guard bit means the sum left the OW-bit range.
        ovf = (sum[OW] != sum[OW-1]);
        if (!ovf)
            opsum_d = sum[OW-1:0];
        else if (sum[OW])
            opsum_d = {1'b1, {(OW-1){1'b0}}};
        else
            opsum_d = {1'b0, {(OW-1){1'b1}}};
`else
        opsum_d = sum;
`endif
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            wreg_q   <= '0;
            x_q      <= '0;
            xvalid_q <= 1'b0;
            prod_q   <= '0;
            psum_q   <= '0;
            mode_q   <= 1'b0;
            clr_q    <= 1'b0;
            v1_q     <= 1'b0;
            acc_q    <= '0;
            opsum_q  <= '0;
            ovalid_q <= 1'b0;
`ifdef PE_SAT_EN
            osat_q   <= 1'b0;
`endif
        end else begin
            if (iWLOAD)
                wreg_q <= iW;
            xvalid_q <= iVALID;
            v1_q     <= iVALID;
            if (iVALID) begin
                x_q    <= iX;
                prod_q <= prod_d;
                psum_q <= iPsum;
                mode_q <= iMODE;
                clr_q  <= iCLR;
            end
            ovalid_q <= v1_q;
            if (v1_q) begin
                opsum_q <= opsum_d;
                if (mode_q)
                    acc_q <= opsum_d;
            end
`ifdef PE_SAT_EN
            osat_q <= v1_q & ovf;
`endif
        end
    end

    assign oX      = x_q;
    assign oXVALID = xvalid_q;
    assign oPsum   = opsum_q;
    assign oVALID  = ovalid_q;
`ifdef PE_SAT_EN
    assign oSAT = osat_q;
`else
    assign oSAT = 1'b0;
`endif

endmodule

// File: tb/tb_pe_mac_pipe.sv
// Directed self-checking bench for pe_mac_pipe (default build and PE_SAT_EN build).
module tb_pe_mac_pipe;

    logic               iCLK = 1'b0;
    logic               iRST = 1'b1;
    logic               iVALID = 1'b0;
    logic signed [15:0] iX = '0;
    logic               iWLOAD = 1'b0;
    logic signed [15:0] iW = '0;
    logic               iMODE = 1'b0;
    logic               iCLR = 1'b0;
    logic signed [33:0] iPsum = '0;
    logic signed [32:0] psum_b;

    logic signed [15:0] oX_a, oX_b;
    logic               oXVALID_a, oXVALID_b;
    logic signed [34:0] oPsum_a;
    logic signed [32:0] oPsum_b;
    logic               oVALID_a, oVALID_b, oSAT_a, oSAT_b;

    assign psum_b = 33'(iPsum);

    pe_mac_pipe u_dut (
        .iCLK(iCLK), .iRST(iRST), .iVALID(iVALID), .iX(iX), .iWLOAD(iWLOAD), .iW(iW),
        .iMODE(iMODE), .iCLR(iCLR), .iPsum(iPsum), .oX(oX_a), .oXVALID(oXVALID_a),
        .oPsum(oPsum_a), .oVALID(oVALID_a), .oSAT(oSAT_a)
    );

    pe_mac_pipe #(.XW(16), .WW(16), .PSW(33), .OW(33)) u_dut33 (
        .iCLK(iCLK), .iRST(iRST), .iVALID(iVALID), .iX(iX), .iWLOAD(iWLOAD), .iW(iW),
        .iMODE(iMODE), .iCLR(iCLR), .iPsum(psum_b), .oX(oX_b), .oXVALID(oXVALID_b),
        .oPsum(oPsum_b), .oVALID(oVALID_b), .oSAT(oSAT_b)
    );

    always #5 iCLK = ~iCLK;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic signed [63:0] got,
                            input logic signed [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Stream table: one row per cycle
    int     sv[10], sx[10], sp[10], sm[10], sc[10], swl[10], sw[10];
    longint se[10];
    longint exp_ox    = 0;
    longint exp_psum  = 0;

    task automatic clear_rows();
        for (int i = 0; i < 10; i++) begin
            sv[i] = 0; sx[i] = 0; sp[i] = 0; sm[i] = 0; sc[i] = 0;
            swl[i] = 0; sw[i] = 0; se[i] = 0;
        end
    endtask

    task automatic row(input int i, input int v, input int x, input int p, input int m,
                       input int c, input int wl, input int w, input longint e);
        sv[i] = v; sx[i] = x; sp[i] = p; sm[i] = m; sc[i] = c;
        swl[i] = wl; sw[i] = w; se[i] = e;
    endtask

    // Drives rows 0..n-1 then one idle cycle; output of row i is checked one cycle after its oX.
    task automatic stream(input int tnum, input int n);
        int prev_v;
        prev_v = 0;
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin
                iVALID = sv[i][0];
                iX     = sv[i] != 0 ? 16'(sx[i]) : 16'sh1234;
                iPsum  = 34'(sp[i]);
                iMODE  = sm[i][0];
                iCLR   = sc[i][0];
                iWLOAD = swl[i][0];
                iW     = 16'(sw[i]);
            end else begin
                iVALID = 1'b0; iX = 16'sh1234; iWLOAD = 1'b0; iCLR = 1'b0;
            end
            @(negedge iCLK);
            if (i < n && sv[i] != 0) exp_ox = sx[i];
            check_eq($sformatf("t%0d.oxvalid[%0d]", tnum, i), 64'(oXVALID_a),
                     (i < n) ? 64'(sv[i]) : 64'sd0);
            check_eq($sformatf("t%0d.ox[%0d]", tnum, i), 64'(oX_a), exp_ox);
            check_eq($sformatf("t%0d.ovalid[%0d]", tnum, i), 64'(oVALID_a), 64'(prev_v));
            if (prev_v != 0) exp_psum = se[i-1];
            check_eq($sformatf("t%0d.psum[%0d]", tnum, i), 64'(oPsum_a), exp_psum);
            check_eq($sformatf("t%0d.osat[%0d]", tnum, i), 64'(oSAT_a), 64'sd0);
            prev_v = (i < n) ? sv[i] : 0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        longint e6[4];
        // Reset state
        #1;
        check_eq("rst.ovalid", 64'(oVALID_a), 0);
        check_eq("rst.psum", 64'(oPsum_a), 0);
        check_eq("rst.oxvalid", 64'(oXVALID_a), 0);
        check_eq("rst.ox", 64'(oX_a), 0);
        check_eq("rst.osat", 64'(oSAT_a), 0);
        @(negedge iCLK); @(negedge iCLK);
        iRST = 1'b0;

        // T1: reset mid-stream with a sample in each stage
        iWLOAD = 1'b1; iW = 16'sd4; @(negedge iCLK); iWLOAD = 1'b0;
        iVALID = 1'b1; iX = 16'sd100; iPsum = 34'sd1; iMODE = 1'b0;
        @(negedge iCLK);
        iX = 16'sd200; iPsum = 34'sd2;
        @(negedge iCLK);
        check_eq("t1.inflight_ovalid", 64'(oVALID_a), 1);
        check_eq("t1.inflight_psum", 64'(oPsum_a), 401);
        iVALID = 1'b0;
        #2 iRST = 1'b1;
        #1;
        check_eq("t1.async_ovalid", 64'(oVALID_a), 0);
        check_eq("t1.async_psum", 64'(oPsum_a), 0);
        check_eq("t1.async_oxvalid", 64'(oXVALID_a), 0);
        check_eq("t1.async_ox", 64'(oX_a), 0);
        @(negedge iCLK);
        iRST = 1'b0;
        exp_ox = 0; exp_psum = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge iCLK);
            check_eq($sformatf("t1.drop_ovalid[%0d]", i), 64'(oVALID_a), 0);
            check_eq($sformatf("t1.drop_psum[%0d]", i), 64'(oPsum_a), 0);
        end

        // T2: weight cleared by reset, then W=3, X=5, psum=10 -> 25; then hold
        clear_rows();
        row(0, 1, 5, 7, 0, 0, 0, 0, 7);
        row(1, 0, 0, 0, 0, 0, 1, 3, 0);
        row(2, 1, 5, 10, 0, 0, 0, 0, 25);
        stream(2, 3);
        @(negedge iCLK);
        check_eq("t2.hold_ovalid", 64'(oVALID_a), 0);
        check_eq("t2.hold_psum", 64'(oPsum_a), 25);
        check_eq("t2.hold_ox", 64'(oX_a), 5);

        // T3: W=-2, back-to-back stream including most negative X
        clear_rows();
        row(0, 0, 0, 0, 0, 0, 1, -2, 0);
        row(1, 1, -32768, 0, 0, 0, 0, 0, 65536);
        row(2, 1, 1, 0, 0, 0, 0, 0, -2);
        row(3, 1, 2, 0, 0, 0, 0, 0, -4);
        row(4, 1, 3, 0, 0, 0, 0, 0, -6);
        stream(3, 5);

        // T4: local accumulate, clear, chain sample leaves acc, invalid clear ignored
        clear_rows();
        row(0, 0, 0, 0, 1, 0, 1, 2, 0);
        row(1, 1, 1, 0, 1, 1, 0, 0, 2);
        row(2, 1, 2, 0, 1, 0, 0, 0, 6);
        row(3, 1, 3, 0, 1, 0, 0, 0, 12);
        row(4, 1, 4, 0, 1, 0, 0, 0, 20);
        row(5, 1, 10, 0, 1, 1, 0, 0, 20);
        row(6, 1, 0, 5, 0, 0, 0, 0, 5);
        row(7, 0, 9, 0, 1, 1, 0, 0, 0);
        row(8, 1, 0, 0, 1, 0, 0, 0, 20);
        stream(4, 9);

        // T5: load and sample in the same cycle uses the old weight
        clear_rows();
        row(0, 0, 0, 0, 0, 0, 1, 3, 0);
        row(1, 1, 1, 0, 0, 0, 1, 7, 3);
        row(2, 1, 1, 0, 0, 0, 0, 0, 7);
        stream(5, 3);

        // T6: OW=PSW=33 instance, local accumulate of (-32768)^2 four times
        e6[0] = 64'sd1073741824;
        e6[1] = 64'sd2147483648;
        e6[2] = 64'sd3221225472;
`ifdef PE_SAT_EN
        e6[3] = 64'sd4294967295;
`else
        e6[3] = -64'sd4294967296;
`endif
        iWLOAD = 1'b1; iW = -16'sd32768; iVALID = 1'b0;
        @(negedge iCLK);
        iWLOAD = 1'b0;
        for (int i = 0; i <= 4; i++) begin
            iVALID = (i < 4);
            iX     = -16'sd32768;
            iMODE  = 1'b1;
            iCLR   = (i == 0);
            iPsum  = '0;
            @(negedge iCLK);
            if (i >= 1) begin
                check_eq($sformatf("t6.ovalid[%0d]", i-1), 64'(oVALID_b), 1);
                check_eq($sformatf("t6.psum[%0d]", i-1), 64'(oPsum_b), e6[i-1]);
`ifdef PE_SAT_EN
                check_eq($sformatf("t6.osat[%0d]", i-1), 64'(oSAT_b), (i == 4) ? 1 : 0);
`else
                check_eq($sformatf("t6.osat[%0d]", i-1), 64'(oSAT_b), 0);
`endif
            end
        end
        iVALID = 1'b0; iCLR = 1'b0;
        @(negedge iCLK);
        check_eq("t6.final_ovalid", 64'(oVALID_b), 0);
        check_eq("t6.final_osat", 64'(oSAT_b), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
